// File: rtl/aes_port_pkg.sv
// aes_port_pkg: shared FSM states, frame type codes and header layout for the output port scheduler.
package aes_port_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BLK, ST_STS} state_e;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] TYPE_BLK  = 8'h01;
  localparam logic [7:0] TYPE_STS  = 8'h02;
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_TYPE_LSB = 16;
  function automatic logic [31:0] hdr_word(input logic [7:0] sync, input logic [7:0] typ, input logic [15:0] seq);
    return (32'(sync) << HDR_SYNC_LSB) | (32'(typ) << HDR_TYPE_LSB) | 32'(seq);
  endfunction
endpackage

// File: rtl/aes_tx_arb.sv
// aes_tx_arb: round-robin framer sharing one 32-bit FWFT word stream between AES blocks and status words.
module aes_tx_arb
  import aes_port_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = aes_port_pkg::SYNC_BYTE,
  parameter logic [7:0] TYPE_BLK  = aes_port_pkg::TYPE_BLK,
  parameter logic [7:0] TYPE_STS  = aes_port_pkg::TYPE_STS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  input  logic         sts_valid,
  input  logic [31:0]  sts_data,
  output logic         sts_ready,
  output logic [31:0]  out_data,
  output logic         out_empty,
  input  logic         out_pop,
  output logic         busy,
  output logic [15:0]  frame_seq
);
  state_e            state_q;
  logic              prio_blk_q;
  logic              is_blk_q;
  logic [1:0]        idx_q;
  logic [15:0]       seq_q;
  logic [3:0][31:0]  payload_q;
  logic              idle;
  assign idle      = state_q == ST_IDLE;
  assign blk_ready = idle & blk_valid & (prio_blk_q | ~sts_valid);
  assign sts_ready = idle & sts_valid & ~blk_ready;
  assign busy      = ~idle;
  assign out_empty = idle;
  assign frame_seq = seq_q;
  // word0 sits in the top lane, so the lane is the inverted word index
  assign out_data  = state_q == ST_HDR ? hdr_word(SYNC_BYTE, is_blk_q ? TYPE_BLK : TYPE_STS, seq_q) :
                     state_q == ST_BLK ? payload_q[~idx_q] :
                     state_q == ST_STS ? payload_q[0] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prio_blk_q <= 1'b1;
      is_blk_q   <= 1'b0;
      idx_q      <= '0;
      seq_q      <= '0;
      payload_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (blk_ready | sts_ready) begin
          payload_q  <= blk_ready ? blk_data : {96'b0, sts_data};
          is_blk_q   <= blk_ready;
          prio_blk_q <= ~prio_blk_q;
          state_q    <= ST_HDR;
        end
        ST_HDR: if (out_pop) begin
          seq_q   <= seq_q + 16'd1;
          idx_q   <= '0;
          state_q <= is_blk_q ? ST_BLK : ST_STS;
        end
        ST_BLK: if (out_pop) begin
          idx_q   <= idx_q + 2'd1;
          state_q <= idx_q == 2'd3 ? ST_IDLE : ST_BLK;
        end
        ST_STS: if (out_pop) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
endmodule
